alu_regfile: RTL and testbench
==============================

Name: alu_regfile

Overview:
- Register file feeding the N-bit ALU's A and B operand inputs from two read ports.
- Stores the ALU Result through one write port.
- Holds a status register that captures the ALU's ONZ flags (overflow, negative, zero) for use by later control logic.
- Sits directly upstream of the ALU (operands) and directly downstream of it (Result/ONZ writeback), closing the datapath loop.

Parameters:
- N, 4, data width; must equal the ALU's N.
- M, 3, address width; the file holds 2^M registers of N bits.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- WD  in  N  write data, normally the ALU Result.
- WAddr  in  M  write address.
- Write  in  1  write enable.
- RA  in  M  read address, port A.
- ReadA  in  1  read enable, port A.
- RB  in  M  read address, port B.
- ReadB  in  1  read enable, port B.
- ONZ_in  in  3  flags from the ALU; [2]=O, [1]=N, [0]=Z.
- Flag_en  in  1  status register load enable.
- QA  out  N  registered operand A, drives ALU A.
- QB  out  N  registered operand B, drives ALU B.
- ONZ_q  out  3  registered status flags.

Behaviour:
- Reset and clock: one clock (clk); rst is synchronous and active-high, sampled on the rising edge.
- Reset values: when rst=1 at an edge, all 2^M registers, QA, QB and ONZ_q become 0. Reset overrides Write, ReadA, ReadB and Flag_en in the same cycle. Asserting rst mid-sequence discards any write presented in that cycle.
- Write: if Write=1 at an edge, RF[WAddr] <= WD. Every register, including address 0, is writable; there is no hardwired zero. If Write=0, the array is unchanged.
- Read port A: registered, 1-cycle latency. At an edge:
  - If ReadA=1, QA <= RF[RA].
  - If ReadA=1 and Write=1 and WAddr==RA, the bypass applies: QA <= WD (new data, write-first).
  - If ReadA=0, QA <= 0 (not hold).
- Read port B: identical rules to port A, using RB, ReadB and QB.
- Both ports may read the same address in the same cycle; both return identical data, with the bypass applied to each independently.
- Status register: if Flag_en=1 at an edge, ONZ_q <= ONZ_in; otherwise ONZ_q holds. Flag capture is independent of Write.
- Arithmetic/width rules: no arithmetic, no sign or zero extension. Data is stored and returned bit-exact; signedness is the ALU's concern.
- Address handling: addresses use the full M bits; every value of WAddr, RA and RB is a valid register (no out-of-range case).
- Outputs: purely registered; no combinational path from any input to QA, QB or ONZ_q.

Test Plan:
- Reset: after random writes, pulse rst for one cycle; then ReadA=ReadB=1 for each RA/RB 0..7 -> QA=QB=0 one cycle after each address is presented; ONZ_q=3'b000.
- Write then read: write 4'b0101 to R3 and 4'b1010 to R6 in consecutive cycles; then RA=3, RB=6 with ReadA=ReadB=1 -> next cycle QA=4'b0101, QB=4'b1010.
- Bypass: R2 holds 4'b0001; in one cycle set Write=1, WAddr=2, WD=4'b1111 with RA=2, ReadA=1 -> next cycle QA=4'b1111 and R2 reads 4'b1111 afterwards.
- Read disable: R5=4'b0110; ReadA=1, RA=5 gives QA=4'b0110; next cycle ReadA=0 -> QA=0. Repeat on port B with the same result.
- Flags: ONZ_in=3'b110, Flag_en=1 -> ONZ_q=3'b110. Then ONZ_in=3'b001, Flag_en=0 -> ONZ_q stays 3'b110. Then Flag_en=1 -> ONZ_q=3'b001.
- Reset priority: rst=1 with Write=1, WAddr=7, WD=4'b1001, Flag_en=1, ONZ_in=3'b111 -> R7=0, ONZ_q=0 after the edge. Loop test: connect QA/QB to the ALU with OP=0 (add), R1=4'b0011, R2=4'b0100, write Result back to R4 -> R4=4'b0111, ONZ_q=3'b000.

Source files
------------

// File: rtl/alu_regfile_if.sv
// Register-file bus: write port, two read ports and the ALU flag capture.
// master drives requests (datapath control); slave is the register file.
interface alu_regfile_if #(
  parameter int N = 4,
  parameter int M = 3
);
  logic [N-1:0] WD;
  logic [M-1:0] WAddr;
  logic         Write;
  logic [M-1:0] RA;
  logic         ReadA;
  logic [M-1:0] RB;
  logic         ReadB;
  logic [2:0]   ONZ_in;
  logic         Flag_en;
  logic [N-1:0] QA;
  logic [N-1:0] QB;
  logic [2:0]   ONZ_q;

  modport master (
    output WD, WAddr, Write, RA, ReadA, RB, ReadB, ONZ_in, Flag_en,
    input  QA, QB, ONZ_q
  );

  modport slave (
    input  WD, WAddr, Write, RA, ReadA, RB, ReadB, ONZ_in, Flag_en,
    output QA, QB, ONZ_q
  );
endinterface

// File: rtl/alu_regfile.sv
// 2^M x N register file with registered dual read ports, write-first bypass,
// and an ONZ status register, feeding and capturing from the ALU.
module alu_regfile #(
  parameter int N = 4,
  parameter int M = 3
) (
  input logic          clk,
  input logic          rst,
  alu_regfile_if.slave bus
);

  localparam int unsigned DEPTH = 1 << M;

  logic [N-1:0] rf [DEPTH];
  logic [N-1:0] rd_a;
  logic [N-1:0] rd_b;

  // Write-first: a same-cycle write to the read address returns the new data.
  always_comb begin
    rd_a = rf[bus.RA];
    rd_b = rf[bus.RB];
    if (bus.Write && (bus.WAddr == bus.RA)) rd_a = bus.WD;
    if (bus.Write && (bus.WAddr == bus.RB)) rd_b = bus.WD;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf        <= '{default: '0};
      bus.QA    <= '0;
      bus.QB    <= '0;
      bus.ONZ_q <= '0;
    end else begin
      if (bus.Write) rf[bus.WAddr] <= bus.WD;
      // A disabled read port returns zero rather than holding its last value.
      bus.QA <= bus.ReadA ? rd_a : '0;
      bus.QB <= bus.ReadB ? rd_b : '0;
      if (bus.Flag_en) bus.ONZ_q <= bus.ONZ_in;
    end
  end

endmodule

// File: tb/tb_alu_regfile.sv
// Scenario bench for alu_regfile: expected QA/QB/ONZ_q are queued as each
// cycle is driven and popped once the registered outputs have updated.
module tb_alu_regfile;

  typedef struct {
    logic [3:0] qa;
    logic [3:0] qb;
    logic [2:0] onz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  alu_regfile_if #(.N(4), .M(3)) bus ();
  alu_regfile #(.N(4), .M(3)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Drive one cycle of inputs at the falling edge, then wait until just after
  // the rising edge so the registered outputs reflect that cycle.
  task automatic apply(input logic r, input logic w, input logic [3:0] wd,
                       input logic [2:0] wa, input logic ra_en,
                       input logic [2:0] ra, input logic rb_en,
                       input logic [2:0] rb, input logic fe,
                       input logic [2:0] onz);
    @(negedge clk);
    rst = r; bus.Write = w; bus.WD = wd; bus.WAddr = wa;
    bus.ReadA = ra_en; bus.RA = ra; bus.ReadB = rb_en; bus.RB = rb;
    bus.Flag_en = fe; bus.ONZ_in = onz;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t e;
    exp_q.push_back('{4'h0, 4'h0, 3'b000});
    apply(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 3'b000);
    e = exp_q.pop_front(); n_cmp++;
    if ({bus.QA, bus.QB, bus.ONZ_q} !== {e.qa, e.qb, e.onz}) begin
      n_err++;
      $display("FAIL reset_state: got %b/%b/%b want %b/%b/%b", bus.QA, bus.QB, bus.ONZ_q, e.qa, e.qb, e.onz);
    end
    for (int i = 0; i < 8; i++)
      apply(0, 1, 4'($urandom), 3'(i), 0, 0, 0, 0, 1, 3'($urandom | 1));
    exp_q.push_back('{4'h0, 4'h0, 3'b000});
    apply(1, 0, 4'h0, 0, 0, 0, 0, 0, 0, 3'b000);
    e = exp_q.pop_front(); n_cmp++;
    if ({bus.QA, bus.QB, bus.ONZ_q} !== {e.qa, e.qb, e.onz}) begin
      n_err++;
      $display("FAIL reset_pulse: got %b/%b/%b want %b/%b/%b", bus.QA, bus.QB, bus.ONZ_q, e.qa, e.qb, e.onz);
    end
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back('{4'h0, 4'h0, 3'b000});
      apply(0, 0, 4'h0, 0, 1, 3'(i), 1, 3'(7 - i), 0, 3'b000);
      e = exp_q.pop_front(); n_cmp++;
      if ({bus.QA, bus.QB, bus.ONZ_q} !== {e.qa, e.qb, e.onz}) begin
        n_err++;
        $display("FAIL reset_clear_r%0d: got %b/%b/%b want %b/%b/%b", i, bus.QA, bus.QB, bus.ONZ_q, e.qa, e.qb, e.onz);
      end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    apply(0, 1, 4'b0101, 3, 0, 0, 0, 0, 0, 3'b000);
    apply(0, 1, 4'b1010, 6, 0, 0, 0, 0, 0, 3'b000);
    exp_q.push_back('{4'b0101, 4'b1010, 3'b000});
    apply(0, 0, 4'h0, 0, 1, 3, 1, 6, 0, 3'b000);
    e = exp_q.pop_front(); n_cmp++;
    if ({bus.QA, bus.QB, bus.ONZ_q} !== {e.qa, e.qb, e.onz}) begin
      n_err++;
      $display("FAIL write_read: got %b/%b/%b want %b/%b/%b", bus.QA, bus.QB, bus.ONZ_q, e.qa, e.qb, e.onz);
    end
    // Register 0 is an ordinary register, read by both ports at once.
    apply(0, 1, 4'b1100, 0, 0, 0, 0, 0, 0, 3'b000);
    exp_q.push_back('{4'b1100, 4'b1100, 3'b000});
    apply(0, 0, 4'h0, 0, 1, 0, 1, 0, 0, 3'b000);
    e = exp_q.pop_front(); n_cmp++;
    if ({bus.QA, bus.QB, bus.ONZ_q} !== {e.qa, e.qb, e.onz}) begin
      n_err++;
      $display("FAIL r0_writable: got %b/%b/%b want %b/%b/%b", bus.QA, bus.QB, bus.ONZ_q, e.qa, e.qb, e.onz);
    end
  endtask

  task automatic test_bypass();
    exp_t e;
    apply(0, 1, 4'b0001, 2, 0, 0, 0, 0, 0, 3'b000);
    exp_q.push_back('{4'b1111, 4'b1111, 3'b000});
    apply(0, 1, 4'b1111, 2, 1, 2, 1, 2, 0, 3'b000);
    e = exp_q.pop_front(); n_cmp++;
    if ({bus.QA, bus.QB, bus.ONZ_q} !== {e.qa, e.qb, e.onz}) begin
      n_err++;
      $display("FAIL bypass: got %b/%b/%b want %b/%b/%b", bus.QA, bus.QB, bus.ONZ_q, e.qa, e.qb, e.onz);
    end
    // Write to a different address must not disturb either read.
    exp_q.push_back('{4'b1111, 4'b0101, 3'b000});
    apply(0, 1, 4'b1000, 1, 1, 2, 1, 3, 0, 3'b000);
    e = exp_q.pop_front(); n_cmp++;
    if ({bus.QA, bus.QB, bus.ONZ_q} !== {e.qa, e.qb, e.onz}) begin
      n_err++;
      $display("FAIL bypass_after: got %b/%b/%b want %b/%b/%b", bus.QA, bus.QB, bus.ONZ_q, e.qa, e.qb, e.onz);
    end
  endtask

  task automatic test_read_disable();
    exp_t e;
    apply(0, 1, 4'b0110, 5, 0, 0, 0, 0, 0, 3'b000);
    exp_q.push_back('{4'b0110, 4'b0000, 3'b000});
    exp_q.push_back('{4'b0000, 4'b0000, 3'b000});
    exp_q.push_back('{4'b0000, 4'b0110, 3'b000});
    exp_q.push_back('{4'b0000, 4'b0000, 3'b000});
    for (int i = 0; i < 4; i++) begin
      apply(0, 0, 4'h0, 0, (i == 0), 5, (i == 2), 5, 0, 3'b000);
      e = exp_q.pop_front(); n_cmp++;
      if ({bus.QA, bus.QB, bus.ONZ_q} !== {e.qa, e.qb, e.onz}) begin
        n_err++;
        $display("FAIL read_disable_%0d: got %b/%b/%b want %b/%b/%b", i, bus.QA, bus.QB, bus.ONZ_q, e.qa, e.qb, e.onz);
      end
    end
  endtask

  task automatic test_flags();
    exp_t e;
    exp_q.push_back('{4'h0, 4'h0, 3'b110});
    exp_q.push_back('{4'h0, 4'h0, 3'b110});
    exp_q.push_back('{4'h0, 4'h0, 3'b001});
    for (int i = 0; i < 3; i++) begin
      // Flag_en low in the middle step while a write happens alongside.
      apply(0, (i == 1), 4'b0011, 7, 0, 0, 0, 0, (i != 1), (i == 0) ? 3'b110 : 3'b001);
      e = exp_q.pop_front(); n_cmp++;
      if ({bus.QA, bus.QB, bus.ONZ_q} !== {e.qa, e.qb, e.onz}) begin
        n_err++;
        $display("FAIL flags_%0d: got %b/%b/%b want %b/%b/%b", i, bus.QA, bus.QB, bus.ONZ_q, e.qa, e.qb, e.onz);
      end
    end
  endtask

  task automatic test_reset_priority();
    exp_t e;
    exp_q.push_back('{4'h0, 4'h0, 3'b000});
    apply(1, 1, 4'b1001, 7, 1, 7, 1, 7, 1, 3'b111);
    e = exp_q.pop_front(); n_cmp++;
    if ({bus.QA, bus.QB, bus.ONZ_q} !== {e.qa, e.qb, e.onz}) begin
      n_err++;
      $display("FAIL rst_priority: got %b/%b/%b want %b/%b/%b", bus.QA, bus.QB, bus.ONZ_q, e.qa, e.qb, e.onz);
    end
    exp_q.push_back('{4'h0, 4'h0, 3'b000});
    apply(0, 0, 4'h0, 0, 1, 7, 1, 3, 0, 3'b000);
    e = exp_q.pop_front(); n_cmp++;
    if ({bus.QA, bus.QB, bus.ONZ_q} !== {e.qa, e.qb, e.onz}) begin
      n_err++;
      $display("FAIL rst_discard: got %b/%b/%b want %b/%b/%b", bus.QA, bus.QB, bus.ONZ_q, e.qa, e.qb, e.onz);
    end
  endtask

  // Writeback loop through a 4-bit adder modelled in the bench.
  task automatic test_loop();
    exp_t e;
    logic [3:0] sum;
    logic [2:0] onz;
    apply(0, 1, 4'b0011, 1, 0, 0, 0, 0, 0, 3'b000);
    apply(0, 1, 4'b0100, 2, 0, 0, 0, 0, 0, 3'b000);
    exp_q.push_back('{4'b0011, 4'b0100, 3'b000});
    apply(0, 0, 4'h0, 0, 1, 1, 1, 2, 0, 3'b000);
    e = exp_q.pop_front(); n_cmp++;
    if ({bus.QA, bus.QB, bus.ONZ_q} !== {e.qa, e.qb, e.onz}) begin
      n_err++;
      $display("FAIL loop_operands: got %b/%b/%b want %b/%b/%b", bus.QA, bus.QB, bus.ONZ_q, e.qa, e.qb, e.onz);
    end
    sum = bus.QA + bus.QB;
    onz = {(bus.QA[3] == bus.QB[3]) && (sum[3] != bus.QA[3]), sum[3], sum == 4'h0};
    exp_q.push_back('{4'h0, 4'h0, 3'b000});
    apply(0, 1, sum, 4, 0, 0, 0, 0, 1, onz);
    e = exp_q.pop_front(); n_cmp++;
    if ({bus.QA, bus.QB, bus.ONZ_q} !== {e.qa, e.qb, e.onz}) begin
      n_err++;
      $display("FAIL loop_flags: got %b/%b/%b want %b/%b/%b", bus.QA, bus.QB, bus.ONZ_q, e.qa, e.qb, e.onz);
    end
    exp_q.push_back('{4'b0111, 4'b0011, 3'b000});
    apply(0, 0, 4'h0, 0, 1, 4, 1, 1, 0, 3'b000);
    e = exp_q.pop_front(); n_cmp++;
    if ({bus.QA, bus.QB, bus.ONZ_q} !== {e.qa, e.qb, e.onz}) begin
      n_err++;
      $display("FAIL loop_result: got %b/%b/%b want %b/%b/%b", bus.QA, bus.QB, bus.ONZ_q, e.qa, e.qb, e.onz);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.Write = 1'b0; bus.WD = '0; bus.WAddr = '0;
    bus.ReadA = 1'b0; bus.RA = '0; bus.ReadB = 1'b0; bus.RB = '0;
    bus.Flag_en = 1'b0; bus.ONZ_in = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_read_disable();
    test_flags();
    test_reset_priority();
    test_loop();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
